sim_jtag: RTL and testbench
===========================

# sim_jtag

Simulation-only JTAG bridge that lets OpenOCD drive the SoC debug TAP over a TCP socket using the remote_bitbang protocol. Socket I/O is done through DPI-C byte functions. The block decodes the protocol characters in RTL and drives TCK/TMS/TDI/TRSTn into `top`. It raises a non-zero `exit` code, which the simulator top uses to call `$finish`.

## Interface
- `TICK_DELAY`, default 1: clock cycles between socket polls; minimum 1.
- `PORT`, default 9999: TCP port passed to the DPI server on the first poll.
- One clock; reset is asynchronous and active-low.
- `clk_i` in 1: simulation clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `enable` in 1: polling allowed when high.
- `init_done` in 1: polling allowed only when high; tied to deasserted reset upstream.
- `jtag_TCK` out 1: TCK to DUT TAP.
- `jtag_TMS` out 1: TMS.
- `jtag_TDI` out 1: TDI.
- `jtag_TRSTn` out 1: active-low TAP reset.
- `jtag_TDO_data` in 1: TDO from DUT.
- `jtag_TDO_driven` in 1: TDO valid; when low, TDO reads as 1 (pull-up).
- `exit` out 32: 0 while running; non-zero requests simulation end.

## Operation
- DPI imports:
  - `int jtag_recv(input int port)` returns a byte 0..255, or -1 when no data, or -2 when the connection is closed.
  - `void jtag_send(input byte c)` sends one byte.
- Decoding of a received byte:
  - '0'..'7': value v sets {TCK,TMS,TDI} = v[2:0].
  - 'r' / 's': TRSTn = 1.
  - 't' / 'u': TRSTn = 0. SRST is not modelled.
  - 'R': send '1' if sampled TDO = 1, else '0'. Sampled TDO = `jtag_TDO_driven` ? `jtag_TDO_data` : 1.
  - 'B' / 'b' (blink): ignored.
  - 'Q': exit = 1.
  - Any other byte: ignored, no state change.
- recv result -2: exit = 2.
- Once exit ≠ 0 it is sticky: no further polls and outputs are frozen until reset.
- Only one byte is processed per poll.
- Outputs are registered. Pin values change only on a processed byte.

## Timing
- Reset values: TCK=0, TMS=0, TDI=0, TRSTn=1, exit=0, tick counter=TICK_DELAY-1.
- Tick counter decrements every `clk_i` cycle. At 0 it reloads TICK_DELAY-1 and asserts `tick` for 1 cycle. With TICK_DELAY=1, `tick` is high every cycle.
- A poll occurs on a `tick` cycle when enable & init_done & (exit==0). `jtag_recv` is called in that cycle's `always_ff`.
- Pin/exit updates are visible the cycle after the poll (1-cycle latency).
- 'R' samples TDO combinationally in the poll cycle; `jtag_send` is called in the same cycle.
- enable or init_done low: the counter keeps running, but polls are skipped and outputs hold.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The socket is not closed; the next poll continues the stream.

## Structure
- `sim_jtag_pkg`: DPI import declarations and command character constants (CMD_READ='R', CMD_QUIT='Q', CMD_RST_*='r'..'u', CMD_BLINK_*).
- Sub-module `sim_jtag_tick_gen` (TICK_DELAY counter producing `tick`).
- The decoder and output registers live in `sim_jtag`.
- The simulator wrapper inverts nothing: it connects `rst_ni` directly and `$finish`es on `|exit`.

## Test plan
- Reset, then stub recv returns -1 forever → TCK/TMS/TDI=0, TRSTn=1, exit=0 throughout.
- Stub feeds '5', then '2' (TICK_DELAY=1) → {TCK,TMS,TDI} = 101 one cycle after the first poll, then 010 one cycle later.
- TICK_DELAY=4 with a byte always available → exactly one recv call every 4 cycles; none while enable=0 or init_done=0.
- TDO_driven=1, TDO_data=0, feed 'R' → send('0'). TDO_driven=0, feed 'R' → send('1').
- Feed 't' then 'r' → TRSTn 0 then 1. Feed 'x' → no change.
- Feed 'Q' → exit=1 next cycle and stays 1 with no further recv calls. Recv -2 → exit=2. Assert rst_ni low → exit=0.

Source files
------------

// File: rtl/sim_jtag_pkg.sv
// sim_jtag_pkg: remote_bitbang command characters, pin state bundle,
// and the socket byte channel (jtag_recv / jtag_send).
package sim_jtag_pkg;

    // recv results that are not data bytes
    localparam int RECV_NONE   = -1;
    localparam int RECV_CLOSED = -2;

    // command characters
    localparam int CMD_PIN_LO    = 48;  // '0'
    localparam int CMD_PIN_HI    = 55;  // '7'
    localparam int CMD_READ      = 82;  // 'R'
    localparam int CMD_QUIT      = 81;  // 'Q'
    localparam int CMD_RST_R     = 114; // 'r'
    localparam int CMD_RST_S     = 115; // 's'
    localparam int CMD_RST_T     = 116; // 't'
    localparam int CMD_RST_U     = 117; // 'u'
    localparam int CMD_BLINK_ON  = 66;  // 'B'
    localparam int CMD_BLINK_OFF = 98;  // 'b'

    localparam byte CHAR_ZERO = 8'h30;
    localparam byte CHAR_ONE  = 8'h31;

    localparam logic [31:0] EXIT_QUIT   = 32'd1;
    localparam logic [31:0] EXIT_CLOSED = 32'd2;

    typedef struct packed {
        logic        tck;
        logic        tms;
        logic        tdi;
        logic        trst_n;
        logic [31:0] code;
    } jtag_state_t;

    localparam jtag_state_t JTAG_RST = '{
        tck: 1'b0, tms: 1'b0, tdi: 1'b0,
        trst_n: 1'b1, code: 32'd0
    };

    // Byte channel. In the socket build these two functions are backed
    // by the C server; here the streams live in package queues so a
    // harness can play the OpenOCD side. A closed connection stays
    // closed: RECV_CLOSED is never consumed.
    int  rx_q[$];
    byte tx_q[$];
    int  recv_calls;
    int  last_port;

    function automatic int jtag_recv(input int port);
        int r;
        recv_calls = recv_calls + 1;
        last_port  = port;
        if (rx_q.size() == 0) begin
            r = RECV_NONE;
        end else if (rx_q[0] == RECV_CLOSED) begin
            r = RECV_CLOSED;
        end else begin
            r = rx_q.pop_front();
        end
        return r;
    endfunction

    function automatic void jtag_send(input byte c);
        tx_q.push_back(c);
    endfunction

endpackage

// File: rtl/sim_jtag_tick_gen.sv
// sim_jtag_tick_gen: down-counter pulsing tick once every TICK_DELAY
// cycles. Ports: clk_i, rst_ni (async low), tick (1-cycle pulse).
module sim_jtag_tick_gen #(
    parameter int unsigned TICK_DELAY = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick
);

    localparam logic [31:0] RELOAD = 32'(TICK_DELAY - 1);

    logic [31:0] cnt_q;

    assign tick = (cnt_q == 32'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RELOAD;
        end else if (tick) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

endmodule

// File: rtl/sim_jtag.sv
// sim_jtag: remote_bitbang decoder driving the debug TAP pins.
// Ports: clk_i/rst_ni, enable/init_done gate polls, jtag_* pins, exit code.
module sim_jtag
    import sim_jtag_pkg::*;
#(
    parameter int unsigned TICK_DELAY = 1,
    parameter int          PORT       = 9999
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable,
    input  logic        init_done,
    output logic        jtag_TCK,
    output logic        jtag_TMS,
    output logic        jtag_TDI,
    output logic        jtag_TRSTn,
    input  logic        jtag_TDO_data,
    input  logic        jtag_TDO_driven,
    output logic [31:0] exit
);

    jtag_state_t st_q;
    logic        tick;
    logic        tdo;
    logic        poll;

    sim_jtag_tick_gen #(
        .TICK_DELAY(TICK_DELAY)
    ) u_tick (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .tick  (tick)
    );

    // undriven TDO floats high
    assign tdo  = jtag_TDO_driven ? jtag_TDO_data : 1'b1;
    assign poll = tick & enable & init_done & (st_q.code == 32'd0);

    // Applies one received byte; 'R' answers on the socket immediately.
    function automatic jtag_state_t step(
        input jtag_state_t s,
        input int          rx,
        input logic        tdo_s
    );
        jtag_state_t n;
        n = s;
        unique case (1'b1)
            (rx == RECV_CLOSED): n.code = EXIT_CLOSED;
            (rx >= CMD_PIN_LO && rx <= CMD_PIN_HI): begin
                n.tck = rx[2];
                n.tms = rx[1];
                n.tdi = rx[0];
            end
            (rx == CMD_RST_R || rx == CMD_RST_S): n.trst_n = 1'b1;
            (rx == CMD_RST_T || rx == CMD_RST_U): n.trst_n = 1'b0;
            (rx == CMD_READ):
                jtag_send(tdo_s ? CHAR_ONE : CHAR_ZERO);
            (rx == CMD_QUIT): n.code = EXIT_QUIT;
            default: ;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q <= JTAG_RST;
        end else if (poll) begin
            st_q <= step(st_q, jtag_recv(PORT), tdo);
        end
    end

    assign jtag_TCK   = st_q.tck;
    assign jtag_TMS   = st_q.tms;
    assign jtag_TDI   = st_q.tdi;
    assign jtag_TRSTn = st_q.trst_n;
    assign exit       = st_q.code;

endmodule

// File: tb/tb_sim_jtag.sv
// tb_sim_jtag: directed bench for sim_jtag, playing the socket side
// through the package byte queues; one instance per TICK_DELAY.
module tb_sim_jtag;

    logic        clk = 1'b0;
    logic        rst1, rst4;
    logic        en1, en4, init1, init4;
    logic        tdo_d, tdo_v;
    logic        tck1, tms1, tdi1, trst1;
    logic        tck4, tms4, tdi4, trst4;
    logic [31:0] exit1, exit4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sim_jtag #(.TICK_DELAY(1), .PORT(9999)) u1 (
        .clk_i          (clk),
        .rst_ni         (rst1),
        .enable         (en1),
        .init_done      (init1),
        .jtag_TCK       (tck1),
        .jtag_TMS       (tms1),
        .jtag_TDI       (tdi1),
        .jtag_TRSTn     (trst1),
        .jtag_TDO_data  (tdo_d),
        .jtag_TDO_driven(tdo_v),
        .exit           (exit1)
    );

    sim_jtag #(.TICK_DELAY(4), .PORT(9999)) u4 (
        .clk_i          (clk),
        .rst_ni         (rst4),
        .enable         (en4),
        .init_done      (init4),
        .jtag_TCK       (tck4),
        .jtag_TMS       (tms4),
        .jtag_TDI       (tdi4),
        .jtag_TRSTn     (trst4),
        .jtag_TDO_data  (tdo_d),
        .jtag_TDO_driven(tdo_v),
        .exit           (exit4)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic feed(input int b);
        sim_jtag_pkg::rx_q.push_back(b);
    endtask

    task automatic test_reset();
        int c0;
        c0 = sim_jtag_pkg::recv_calls;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            checks++;
            if ({tck1, tms1, tdi1, trst1} !== 4'b0001 || exit1 !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got pins %b exit %0d want 0001 exit 0",
                         i, {tck1, tms1, tdi1, trst1}, exit1);
            end
        end
        checks++;
        if (sim_jtag_pkg::recv_calls - c0 !== 4) begin
            errors++;
            $display("FAIL reset_polls got %0d want 4", sim_jtag_pkg::recv_calls - c0);
        end
        checks++;
        if (sim_jtag_pkg::last_port !== 9999) begin
            errors++;
            $display("FAIL port got %0d want 9999", sim_jtag_pkg::last_port);
        end
    endtask

    task automatic test_pins();
        feed(53);
        feed(50);
        cyc(1);
        checks++;
        if ({tck1, tms1, tdi1} !== 3'b101) begin
            errors++;
            $display("FAIL pins_5 got %b want 101", {tck1, tms1, tdi1});
        end
        cyc(1);
        checks++;
        if ({tck1, tms1, tdi1} !== 3'b010) begin
            errors++;
            $display("FAIL pins_2 got %b want 010", {tck1, tms1, tdi1});
        end
    endtask

    task automatic test_read();
        logic [2:0] dv [3] = '{3'b010, 3'b000, 3'b011};
        byte        want [3] = '{8'h30, 8'h31, 8'h31};
        for (int i = 0; i < 3; i++) begin
            sim_jtag_pkg::tx_q.delete();
            tdo_v = dv[i][1];
            tdo_d = dv[i][0];
            feed(82);
            cyc(1);
            checks++;
            if (sim_jtag_pkg::tx_q.size() != 1 || sim_jtag_pkg::tx_q[0] !== want[i]) begin
                errors++;
                $display("FAIL read_%0d got n=%0d want one byte %0d",
                         i, sim_jtag_pkg::tx_q.size(), want[i]);
            end
        end
        checks++;
        if ({tck1, tms1, tdi1, trst1} !== 4'b0101) begin
            errors++;
            $display("FAIL read_pins got %b want 0101", {tck1, tms1, tdi1, trst1});
        end
    endtask

    task automatic test_trst();
        int   cmd [6] = '{116, 114, 117, 115, 120, 66};
        logic want [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            feed(cmd[i]);
            cyc(1);
            checks++;
            if (trst1 !== want[i] || {tck1, tms1, tdi1} !== 3'b010 || exit1 !== 32'd0) begin
                errors++;
                $display("FAIL trst_%0d got trst %b pins %b exit %0d want trst %b pins 010",
                         cmd[i], trst1, {tck1, tms1, tdi1}, exit1, want[i]);
            end
        end
    endtask

    task automatic test_tick();
        int c0;
        en1 = 1'b0;
        for (int i = 0; i < 40; i++) feed(120);
        en4   = 1'b1;
        init4 = 1'b1;
        c0 = sim_jtag_pkg::recv_calls;
        cyc(16);
        checks++;
        if (sim_jtag_pkg::recv_calls - c0 !== 4) begin
            errors++;
            $display("FAIL tick4_polls got %0d want 4", sim_jtag_pkg::recv_calls - c0);
        end
        en4 = 1'b0;
        c0 = sim_jtag_pkg::recv_calls;
        cyc(16);
        checks++;
        if (sim_jtag_pkg::recv_calls - c0 !== 0) begin
            errors++;
            $display("FAIL tick4_disabled got %0d want 0", sim_jtag_pkg::recv_calls - c0);
        end
        en4   = 1'b1;
        init4 = 1'b0;
        c0 = sim_jtag_pkg::recv_calls;
        cyc(16);
        checks++;
        if (sim_jtag_pkg::recv_calls - c0 !== 0) begin
            errors++;
            $display("FAIL tick4_no_init got %0d want 0", sim_jtag_pkg::recv_calls - c0);
        end
        checks++;
        if ({tck4, tms4, tdi4, trst4} !== 4'b0001 || exit4 !== 32'd0) begin
            errors++;
            $display("FAIL tick4_pins got %b exit %0d want 0001 exit 0",
                     {tck4, tms4, tdi4, trst4}, exit4);
        end
        en4 = 1'b0;
        sim_jtag_pkg::rx_q.delete();
        en1 = 1'b1;
    endtask

    task automatic test_quit();
        int c0;
        feed(81);
        cyc(1);
        checks++;
        if (exit1 !== 32'd1) begin
            errors++;
            $display("FAIL quit got %0d want 1", exit1);
        end
        feed(55);
        c0 = sim_jtag_pkg::recv_calls;
        cyc(8);
        checks++;
        if (sim_jtag_pkg::recv_calls - c0 !== 0 || exit1 !== 32'd1 ||
            {tck1, tms1, tdi1, trst1} !== 4'b0101) begin
            errors++;
            $display("FAIL quit_sticky got polls %0d exit %0d pins %b want 0 1 0101",
                     sim_jtag_pkg::recv_calls - c0, exit1, {tck1, tms1, tdi1, trst1});
        end
    endtask

    task automatic test_reset_mid();
        rst1 = 1'b0;
        #1;
        checks++;
        if (exit1 !== 32'd0 || {tck1, tms1, tdi1, trst1} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset got exit %0d pins %b want 0 0001",
                     exit1, {tck1, tms1, tdi1, trst1});
        end
        cyc(1);
        rst1 = 1'b1;
        cyc(1);
        checks++;
        if ({tck1, tms1, tdi1, trst1} !== 4'b1111) begin
            errors++;
            $display("FAIL resume_stream got %b want 1111", {tck1, tms1, tdi1, trst1});
        end
        feed(-2);
        cyc(1);
        checks++;
        if (exit1 !== 32'd2) begin
            errors++;
            $display("FAIL closed got %0d want 2", exit1);
        end
        cyc(4);
        checks++;
        if (exit1 !== 32'd2 || {tck1, tms1, tdi1, trst1} !== 4'b1111) begin
            errors++;
            $display("FAIL closed_sticky got exit %0d pins %b want 2 1111",
                     exit1, {tck1, tms1, tdi1, trst1});
        end
        rst1 = 1'b0;
        #1;
        checks++;
        if (exit1 !== 32'd0 || {tck1, tms1, tdi1, trst1} !== 4'b0001) begin
            errors++;
            $display("FAIL final_reset got exit %0d pins %b want 0 0001",
                     exit1, {tck1, tms1, tdi1, trst1});
        end
    endtask

    initial begin
        rst1  = 1'b0;
        rst4  = 1'b0;
        en1   = 1'b0;
        en4   = 1'b0;
        init1 = 1'b0;
        init4 = 1'b0;
        tdo_d = 1'b0;
        tdo_v = 1'b0;
        cyc(2);
        rst1  = 1'b1;
        rst4  = 1'b1;
        en1   = 1'b1;
        init1 = 1'b1;
        test_reset();
        test_pins();
        test_read();
        test_trst();
        test_tick();
        test_quit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
